// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with writeback select and load extension
// Define WB_RETIRE_CNT_EN to add the retire_count port and its counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_regWrite,
  input  logic [1:0]      mem_memToReg,
  input  logic [2:0]      mem_funct3,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_aluResult,
  input  logic [XLEN-1:0] mem_readData,
  input  logic [XLEN-1:0] mem_pcPlus4,
  output logic            regWrite,
  output logic [4:0]      writeReg,
  output logic [XLEN-1:0] writeData,
  output logic            wb_valid,
  output logic            fwd_en,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_count
`endif
);

  if (XLEN != 32 || CNT_W < 1) begin : gParamCheck
    $error("wb_stage supports XLEN=32 and CNT_W>=1 only");
  end

  logic            validQ;
  logic            regWriteQ;
  logic [1:0]      memToRegQ;
  logic [2:0]      funct3Q;
  logic [4:0]      rdQ;
  logic [XLEN-1:0] aluResultQ;
  logic [XLEN-1:0] readDataQ;
  logic [XLEN-1:0] pcPlus4Q;

  // Flush only needs to kill the valid/write bits; the payload is don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ     <= 1'b0;
      regWriteQ  <= 1'b0;
      memToRegQ  <= 2'b00;
      funct3Q    <= 3'b000;
      rdQ        <= 5'd0;
      aluResultQ <= '0;
      readDataQ  <= '0;
      pcPlus4Q   <= '0;
    end else if (flush) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
    end else if (!stall) begin
      validQ     <= mem_valid;
      regWriteQ  <= mem_regWrite;
      memToRegQ  <= mem_memToReg;
      funct3Q    <= mem_funct3;
      rdQ        <= mem_rd;
      aluResultQ <= mem_aluResult;
      readDataQ  <= mem_readData;
      pcPlus4Q   <= mem_pcPlus4;
    end
  end

  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] wbData;

  always_comb begin
    loadByte = readDataQ[7:0];
    case (aluResultQ[1:0])
      2'd1:    loadByte = readDataQ[15:8];
      2'd2:    loadByte = readDataQ[23:16];
      2'd3:    loadByte = readDataQ[31:24];
      default: loadByte = readDataQ[7:0];
    endcase
    loadHalf = aluResultQ[1] ? readDataQ[31:16] : readDataQ[15:0];

    loadData = readDataQ;
    case (funct3Q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {24'd0, loadByte};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = readDataQ;
    endcase

    wbData = aluResultQ;
    case (memToRegQ)
      2'b01:   wbData = loadData;
      2'b10:   wbData = pcPlus4Q;
      default: wbData = aluResultQ;
    endcase
  end

  assign regWrite  = validQ & regWriteQ & (rdQ != 5'd0);
  assign writeReg  = rdQ;
  assign writeData = wbData;
  assign wb_valid  = validQ;
  assign fwd_en    = regWrite;
  assign fwd_rd    = rdQ;
  assign fwd_data  = wbData;

`ifdef WB_RETIRE_CNT_EN
  // An instruction leaves WB on any edge that does not hold it, flush included.
  logic [CNT_W-1:0] retireCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      retireCnt <= '0;
    end else if (validQ && (!stall || flush)) begin
      retireCnt <= retireCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retire_count = retireCnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
// Retire-counter scenarios run when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_regWrite;
  logic [1:0]  mem_memToReg;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_aluResult;
  logic [31:0] mem_readData;
  logic [31:0] mem_pcPlus4;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        wb_valid;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [3:0]  retire_count;
`endif

  int passCount = 0;
  int checkCount = 0;

  logic [31:0] rf [0:31];

  wb_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_memToReg(mem_memToReg),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_aluResult(mem_aluResult),
    .mem_readData(mem_readData), .mem_pcPlus4(mem_pcPlus4),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .wb_valid(wb_valid),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model consuming the write port.
  always @(posedge clk) begin
    if (regWrite) rf[writeReg] <= writeData;
  end

  task automatic drive(input logic v, input logic rw, input logic [1:0] m2r, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc);
    mem_valid = v; mem_regWrite = rw; mem_memToReg = m2r; mem_funct3 = f3;
    mem_rd = rd; mem_aluResult = alu; mem_readData = rdat; mem_pcPlus4 = pc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b010, 5'd9, 32'hDEAD_BEEF, 32'h1234_5678, 32'h40);
    step(); step();
    checkCount++; if (regWrite !== 1'b0) $display("FAIL reset_regWrite got %0b want 0", regWrite); else passCount++;
    checkCount++; if (writeReg !== 5'd0) $display("FAIL reset_writeReg got %0d want 0", writeReg); else passCount++;
    checkCount++; if (writeData !== 32'd0) $display("FAIL reset_writeData got %h want 0", writeData); else passCount++;
    checkCount++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %0b want 0", wb_valid); else passCount++;
    checkCount++; if (fwd_en !== 1'b0) $display("FAIL reset_fwd_en got %0b want 0", fwd_en); else passCount++;
`ifdef WB_RETIRE_CNT_EN
    checkCount++; if (retire_count !== 4'd0) $display("FAIL reset_retire got %0d want 0", retire_count); else passCount++;
`endif
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    step();
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd2, 32'd200, 32'h5555_5555, 32'h8);
    step();
    checkCount++; if (regWrite !== 1'b1) $display("FAIL alu_regWrite got %0b want 1", regWrite); else passCount++;
    checkCount++; if (writeReg !== 5'd2) $display("FAIL alu_writeReg got %0d want 2", writeReg); else passCount++;
    checkCount++; if (writeData !== 32'd200) $display("FAIL alu_writeData got %0d want 200", writeData); else passCount++;
    checkCount++; if (fwd_en !== 1'b1 || fwd_rd !== 5'd2 || fwd_data !== 32'd200)
      $display("FAIL alu_fwd got en=%0b rd=%0d data=%0d want 1/2/200", fwd_en, fwd_rd, fwd_data); else passCount++;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    step();
    checkCount++; if (rf[2] !== 32'd200) $display("FAIL alu_rf_x2 got %0d want 200", rf[2]); else passCount++;
    checkCount++; if (regWrite !== 1'b0) $display("FAIL alu_bubble_regWrite got %0b want 0", regWrite); else passCount++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [0:8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b100, 3'b110};
    logic [31:0] adrs [0:8] = '{32'h100, 32'h103, 32'h102, 32'h100, 32'h101, 32'h101, 32'h103, 32'h102, 32'h100};
    logic [31:0] exps [0:8] = '{32'hFFFF_FFBB, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB, 32'h8899_AABB,
                                32'hFFFF_FFAA, 32'hFFFF_8899, 32'h0000_0099, 32'h8899_AABB};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 2'b01, f3s[i], 5'd3, adrs[i], 32'h8899_AABB, 32'h0);
      step();
      checkCount++;
      if (writeData !== exps[i])
        $display("FAIL load_%0d f3=%b addr=%h got %h want %h", i, f3s[i], adrs[i], writeData, exps[i]);
      else passCount++;
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 32'h0000_0F00, 32'h0, 32'h104);
    step();
    checkCount++; if (writeData !== 32'h104) $display("FAIL jal_writeData got %h want 104", writeData); else passCount++;
    checkCount++; if (regWrite !== 1'b1) $display("FAIL jal_regWrite got %0b want 1", regWrite); else passCount++;
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd0, 32'h0000_0F00, 32'h0, 32'h104);
    step();
    checkCount++; if (regWrite !== 1'b0) $display("FAIL jal_x0_regWrite got %0b want 0", regWrite); else passCount++;
    checkCount++; if (wb_valid !== 1'b1) $display("FAIL jal_x0_wb_valid got %0b want 1", wb_valid); else passCount++;
    drive(1'b1, 1'b1, 2'b11, 3'b000, 5'd4, 32'h77, 32'h0, 32'h104);
    step();
    checkCount++; if (writeData !== 32'h77) $display("FAIL reserved_m2r got %h want 77", writeData); else passCount++;
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'd10, 32'h0, 32'h0);
    step();
    stall = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 32'd99, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      checkCount++;
      if (regWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'd10)
        $display("FAIL stall_hold_%0d got we=%0b rd=%0d data=%0d want 1/5/10", c, regWrite, writeReg, writeData);
      else passCount++;
    end
    flush = 1'b1;
    step();
    checkCount++; if (wb_valid !== 1'b0) $display("FAIL flush_wb_valid got %0b want 0", wb_valid); else passCount++;
    checkCount++; if (regWrite !== 1'b0) $display("FAIL flush_regWrite got %0b want 0", regWrite); else passCount++;
    flush = 1'b0; stall = 1'b0;
    step();
    checkCount++; if (writeReg !== 5'd7 || regWrite !== 1'b1) $display("FAIL after_flush got rd=%0d we=%0b want 7/1", writeReg, regWrite); else passCount++;
    drive(1'b0, 1'b1, 2'b00, 3'b000, 5'd8, 32'd1, 32'h0, 32'h0);
    step();
    checkCount++; if (regWrite !== 1'b0) $display("FAIL bubble_regWrite got %0b want 0", regWrite); else passCount++;
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire();
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 32'd1, 32'd0, 32'd0); step();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd2, 32'd2, 32'd0, 32'd0); step();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0); step();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'd3, 32'd0, 32'd0); step();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 32'd4, 32'd0, 32'd0); step();
    stall = 1'b1; step(); step(); stall = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0); step(); step();
    checkCount++; if (retire_count !== 4'd4) $display("FAIL retire_four got %0d want 4", retire_count); else passCount++;

    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 32'd1, 32'd0, 32'd0);
    for (int k = 0; k < 16; k++) step();
    checkCount++; if (retire_count !== 4'd15) $display("FAIL retire_fifteen got %0d want 15", retire_count); else passCount++;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0); step();
    checkCount++; if (retire_count !== 4'd0) $display("FAIL retire_wrap got %0d want 0", retire_count); else passCount++;

    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 32'd1, 32'd0, 32'd0); step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    checkCount++; if (retire_count !== 4'd0) $display("FAIL retire_reset got %0d want 0", retire_count); else passCount++;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_jal();
    test_stall_flush();
`ifdef WB_RETIRE_CNT_EN
    test_retire();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
